// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions used by the writeback stage.
// Holds opcode/funct constants, the writeback source select enum,
// the load-type enum handed to the load extractor, and the zero register index.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JALR  = 6'b001001;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_DM  = 2'd1,
    WB_PC8 = 2'd2
  } wb_sel_e;

  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_BU = 3'd2,
    LD_H  = 3'd3,
    LD_HU = 3'd4
  } ld_type_e;

endpackage

// File: rtl/w_stage_regfile_load_ext.sv
// load_ext: combinational data extractor for the writeback stage.
// Picks the addressed byte/halfword out of an aligned little-endian memory
// word and sign- or zero-extends it to 32 bits; word loads pass through.
// Ports:
//   dm       in  32  aligned data-memory word
//   byte_off in  2   low address bits (alu_w[1:0])
//   ld_type  in      load type (word / byte / half, signed or unsigned)
//   ext_data out 32  extended load data
module load_ext
  import mips_pkg::*;
(
  input  logic [31:0] dm,
  input  logic [1:0]  byte_off,
  input  ld_type_e    ld_type,
  output logic [31:0] ext_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Byte lane and halfword lane selection from the address offset.
  always_comb begin
    byte_v = 8'd0;
    case (byte_off)
      2'd0:    byte_v = dm[7:0];
      2'd1:    byte_v = dm[15:8];
      2'd2:    byte_v = dm[23:16];
      2'd3:    byte_v = dm[31:24];
      default: byte_v = 8'd0;
    endcase
    // byte_off[0] is deliberately ignored for halfwords.
    if (byte_off[1]) begin
      half_v = dm[31:16];
    end else begin
      half_v = dm[15:0];
    end
  end

  // Extension according to load type.
  always_comb begin
    ext_data = dm;
    case (ld_type)
      LD_W:    ext_data = dm;
      LD_B:    ext_data = {{24{byte_v[7]}}, byte_v};
      LD_BU:   ext_data = {24'd0, byte_v};
      LD_H:    ext_data = {{16{half_v[15]}}, half_v};
      LD_HU:   ext_data = {16'd0, half_v};
      default: ext_data = dm;
    endcase
  end

endmodule

// File: rtl/w_stage_regfile.sv
// w_stage_regfile: MIPS writeback stage plus 32x32 architectural register file.
// Selects the writeback value (ALU, extended load data or link address),
// commits it to the register file, serves two decode read ports with
// same-cycle write-through bypass and counts retired (non-bubble) instructions.
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   ir_w, pc4_w, pc8_w    W-stage instruction, PC+4 (unused), PC+8 link value
//   alu_w, dm_w, rdst_w   ALU result, aligned memory word, destination reg
//   ra1/ra2 -> rd1/rd2    combinational read ports with bypass
//   wb_we/wb_addr/wb_data committed write, exported for forwarding
//   retired_cnt           retired instruction count (wraps)
module w_stage_regfile
  import mips_pkg::*;
#(
  parameter int NREG  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      ir_w,
  input  logic [31:0]      pc4_w,
  input  logic [31:0]      pc8_w,
  input  logic [31:0]      alu_w,
  input  logic [31:0]      dm_w,
  input  logic [4:0]       rdst_w,
  input  logic [4:0]       ra1,
  input  logic [4:0]       ra2,
  output logic [31:0]      rd1,
  output logic [31:0]      rd2,
  output logic             wb_we,
  output logic [4:0]       wb_addr,
  output logic [31:0]      wb_data,
  output logic [CNT_W-1:0] retired_cnt
);

  logic [31:0]      regs [NREG];
  logic [CNT_W-1:0] cnt_r;
  logic [5:0]       op;
  logic [5:0]       funct;
  wb_sel_e          wb_sel;
  ld_type_e         ld_type;
  logic [31:0]      ld_data;
  logic             unused_ok;

  assign op        = ir_w[31:26];
  assign funct     = ir_w[5:0];
  // PC+4 and the middle instruction fields are not needed in this stage.
  assign unused_ok = ^{pc4_w, ir_w[25:6]};

  // Decode writeback source and load type from opcode/funct.
  always_comb begin
    wb_sel  = WB_ALU;
    ld_type = LD_W;
    case (op)
      OP_LW:  begin wb_sel = WB_DM; ld_type = LD_W;  end
      OP_LB:  begin wb_sel = WB_DM; ld_type = LD_B;  end
      OP_LBU: begin wb_sel = WB_DM; ld_type = LD_BU; end
      OP_LH:  begin wb_sel = WB_DM; ld_type = LD_H;  end
      OP_LHU: begin wb_sel = WB_DM; ld_type = LD_HU; end
      OP_JAL: begin wb_sel = WB_PC8; end
      OP_RTYPE: begin
        if (funct == FN_JALR) begin
          wb_sel = WB_PC8;
        end else begin
          wb_sel = WB_ALU;
        end
      end
      default: begin wb_sel = WB_ALU; ld_type = LD_W; end
    endcase
  end

  load_ext u_load_ext (
    .dm       (dm_w),
    .byte_off (alu_w[1:0]),
    .ld_type  (ld_type),
    .ext_data (ld_data)
  );

  // Writeback value mux and write-enable; the write decision is made upstream.
  always_comb begin
    case (wb_sel)
      WB_DM:   wb_data = ld_data;
      WB_PC8:  wb_data = pc8_w;
      WB_ALU:  wb_data = alu_w;
      default: wb_data = alu_w;
    endcase
    wb_we   = (rdst_w != REG_ZERO);
    wb_addr = rdst_w;
  end

  // Register file commit; reset wins over a concurrent write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= 32'd0;
      end
    end else if (wb_we) begin
      regs[rdst_w] <= wb_data;
    end
  end

  // Read ports: zero register, then write-through bypass, then array.
  always_comb begin
    if (ra1 == REG_ZERO) begin
      rd1 = 32'd0;
    end else if (wb_we && (ra1 == rdst_w)) begin
      rd1 = wb_data;
    end else begin
      rd1 = regs[ra1];
    end
    if (ra2 == REG_ZERO) begin
      rd2 = 32'd0;
    end else if (wb_we && (ra2 == rdst_w)) begin
      rd2 = wb_data;
    end else begin
      rd2 = regs[ra2];
    end
  end

  // Retired-instruction counter; any non-zero instruction word retires.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (ir_w != 32'd0) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign retired_cnt = cnt_r;

endmodule

// File: tb/tb_w_stage_regfile.sv
// Directed, scoreboard-based bench for w_stage_regfile.
module tb_w_stage_regfile;

  logic        clk;
  logic        reset;
  logic [31:0] ir_w, pc4_w, pc8_w, alu_w, dm_w;
  logic [4:0]  rdst_w, ra1, ra2;
  logic [31:0] rd1, rd2, wb_data;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] retired_cnt;

  int total;
  int bad;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  localparam logic [31:0] I_ADDU = 32'h01095021; // op 0, funct 0x21
  localparam logic [31:0] I_SW   = 32'hAD090004; // op 101011
  localparam logic [31:0] I_LW   = 32'h8D0B0000; // op 100011
  localparam logic [31:0] I_LB   = 32'h81000000;
  localparam logic [31:0] I_LBU  = 32'h91000000;
  localparam logic [31:0] I_LH   = 32'h85000000;
  localparam logic [31:0] I_LHU  = 32'h95000000;
  localparam logic [31:0] I_JAL  = 32'h0C000C00;
  localparam logic [31:0] I_JALR = 32'h00402009; // jalr r4, r2

  w_stage_regfile #(.NREG(32), .CNT_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .ir_w        (ir_w),
    .pc4_w       (pc4_w),
    .pc8_w       (pc8_w),
    .alu_w       (alu_w),
    .dm_w        (dm_w),
    .rdst_w      (rdst_w),
    .ra1         (ra1),
    .ra2         (ra2),
    .rd1         (rd1),
    .rd2         (rd2),
    .wb_we       (wb_we),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .retired_cnt (retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_exp(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  // Advance one clock, leaving inputs to be driven 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ir, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] dm,
                       input logic [31:0] pc8);
    ir_w = ir; rdst_w = rd; alu_w = alu; dm_w = dm; pc8_w = pc8;
    pc4_w = pc8 - 32'd4;
  endtask

  task automatic bubble();
    drive(32'd0, 5'd0, 32'd0, 32'd0, 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    ra1 = 5'd0; ra2 = 5'd0;
    bubble();
    step(); step();
    reset = 1'b0;
    ra1 = 5'd5; ra2 = 5'd31;
    #2;
    push_exp("reset_rd1", 32'd0);        check(rd1);
    push_exp("reset_rd2", 32'd0);        check(rd2);
    push_exp("reset_cnt", 32'd0);        check(retired_cnt);

    // Reset clear of a written register and the counter
    drive(I_ADDU, 5'd5, 32'hDEADBEEF, 32'd0, 32'd0);
    step();
    bubble();
    #2;
    push_exp("r5_written", 32'hDEADBEEF); check(rd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #2;
    push_exp("r5_after_reset", 32'd0);   check(rd1);
    push_exp("cnt_after_reset", 32'd0);  check(retired_cnt);

    // Bypass on both ports, then commit
    drive(I_ADDU, 5'd8, 32'h12345678, 32'd0, 32'd0);
    ra1 = 5'd8; ra2 = 5'd8;
    #2;
    push_exp("bypass_rd1", 32'h12345678); check(rd1);
    push_exp("bypass_rd2", 32'h12345678); check(rd2);
    push_exp("bypass_we", 32'd1);         check({31'd0, wb_we});
    push_exp("bypass_addr", 32'd8);       check({27'd0, wb_addr});
    step();
    bubble();
    #2;
    push_exp("commit_rd1", 32'h12345678); check(rd1);
    push_exp("commit_we", 32'd0);         check({31'd0, wb_we});

    // Zero register is never written
    drive(I_ADDU, 5'd0, 32'hFFFFFFFF, 32'd0, 32'd0);
    ra1 = 5'd0;
    #2;
    push_exp("zero_we", 32'd0);           check({31'd0, wb_we});
    push_exp("zero_rd1", 32'd0);          check(rd1);
    step();
    bubble();
    #2;
    push_exp("zero_later", 32'd0);        check(rd1);

    // Byte/halfword loads from 0x80FF7F01
    drive(I_LB, 5'd9, 32'h00001003, 32'h80FF7F01, 32'd0);
    #2; push_exp("lb_off3", 32'hFFFFFF80);  check(wb_data);
    drive(I_LBU, 5'd9, 32'h00001003, 32'h80FF7F01, 32'd0);
    #2; push_exp("lbu_off3", 32'h00000080); check(wb_data);
    drive(I_LB, 5'd9, 32'h00001001, 32'h80FF7F01, 32'd0);
    #2; push_exp("lb_off1", 32'h0000007F);  check(wb_data);
    drive(I_LH, 5'd9, 32'h00001003, 32'h80FF7F01, 32'd0);
    #2; push_exp("lh_hi", 32'hFFFF80FF);    check(wb_data);
    drive(I_LHU, 5'd9, 32'h00001000, 32'h80FF7F01, 32'd0);
    #2; push_exp("lhu_lo", 32'h00007F01);   check(wb_data);
    drive(I_LBU, 5'd9, 32'h00001002, 32'h80FF7F01, 32'd0);
    #2; push_exp("lbu_off2", 32'h000000FF); check(wb_data);
    drive(I_LW, 5'd10, 32'h00001000, 32'h80FF7F01, 32'd0);
    ra2 = 5'd10;
    #2; push_exp("lw_bypass", 32'h80FF7F01); check(rd2);
    step();
    bubble();
    #2; push_exp("lw_commit", 32'h80FF7F01); check(rd2);

    // Link: jal and jalr
    drive(I_JAL, 5'd31, 32'h0000AAAA, 32'd0, 32'h00003008);
    step();
    drive(I_JALR, 5'd4, 32'h0000BBBB, 32'd0, 32'h00004444);
    ra1 = 5'd31;
    #2;
    push_exp("jal_reg31", 32'h00003008);   check(rd1);
    push_exp("jalr_wb", 32'h00004444);     check(wb_data);
    step();
    bubble();
    ra2 = 5'd4;
    #2;
    push_exp("jalr_reg4", 32'h00004444);   check(rd2);

    // Counter: addu, bubble, sw, bubble, lw -> 3
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(I_ADDU, 5'd12, 32'd1, 32'd0, 32'd0); step();
    bubble();                                  step();
    drive(I_SW, 5'd0, 32'd4, 32'd0, 32'd0);    step();
    bubble();                                  step();
    drive(I_LW, 5'd11, 32'd0, 32'h5, 32'd0);   step();
    bubble();
    #2;
    push_exp("cnt_seq", 32'd3);            check(retired_cnt);

    // Counter wrap
    force dut.cnt_r = 32'hFFFFFFFF;
    #1;
    release dut.cnt_r;
    #1;
    push_exp("cnt_preload", 32'hFFFFFFFF); check(retired_cnt);
    drive(I_ADDU, 5'd0, 32'd0, 32'd0, 32'd0);
    step();
    bubble();
    #2;
    push_exp("cnt_wrap", 32'd0);           check(retired_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
